// File: rtl/pcoeff_batch_aggregator.sv
`default_nettype none
// ============================================================================
// Module   : pcoeff_batch_aggregator
// Purpose  : Accumulates 2^connectCount per bot into per-batch (sum, count)
//            pairs, queues finished batches in a show-ahead result FIFO with
//            a ready/valid output, throttles upstream via slowDownInput and
//            keeps sticky error flags for range, overflow and drop events.
// Ports    : clk, rst (async, active-high)
//            connectCountValid / connectCount / batchEnd : bot stream input
//            slowDownInput                               : upstream throttle
//            resultValid / resultReady / pcoeffSum / pcoeffCount : result out
//            errClear, rangeError, countOverflow, resultDropped  : error flags
// Revision : 1.0 - initial release
// ============================================================================
module pcoeff_batch_aggregator #(
  parameter int PCOEFF_COUNT_BITWIDTH = 10,
  parameter int CONNECT_COUNT_WIDTH   = 6,
  parameter int MAX_CONNECT_COUNT     = 35,
  parameter int SUM_WIDTH             = PCOEFF_COUNT_BITWIDTH + MAX_CONNECT_COUNT + 1,
  parameter int FIFO_DEPTH_LOG2       = 2,
  parameter int SLOWDOWN_MARGIN       = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             connectCountValid,
  input  logic [CONNECT_COUNT_WIDTH-1:0]   connectCount,
  input  logic                             batchEnd,
  output logic                             slowDownInput,
  output logic                             resultValid,
  input  logic                             resultReady,
  output logic [SUM_WIDTH-1:0]             pcoeffSum,
  output logic [PCOEFF_COUNT_BITWIDTH-1:0] pcoeffCount,
  input  logic                             errClear,
  output logic                             rangeError,
  output logic                             countOverflow,
  output logic                             resultDropped
);

  localparam int c_DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int c_PW    = FIFO_DEPTH_LOG2 + 1;

  // --------------------------------------------------------------------------
  // Accumulator
  // --------------------------------------------------------------------------
  logic [SUM_WIDTH-1:0]             r_sum;
  logic [PCOEFF_COUNT_BITWIDTH-1:0] r_cnt;

  logic                             w_in_range;
  logic                             w_cnt_full;
  logic                             w_accept;
  logic [SUM_WIDTH-1:0]             w_addend;
  logic [SUM_WIDTH-1:0]             w_next_sum;
  logic [PCOEFF_COUNT_BITWIDTH-1:0] w_next_cnt;

  assign w_in_range = (32'(connectCount) <= 32'(MAX_CONNECT_COUNT));
  assign w_cnt_full = &r_cnt;
  assign w_accept   = connectCountValid && w_in_range && !w_cnt_full;

  // The shift amount is only used when in range, so it never exceeds the sum.
  assign w_addend   = w_accept ? (SUM_WIDTH'(1) << connectCount) : '0;
  assign w_next_sum = r_sum + w_addend;
  assign w_next_cnt = r_cnt + PCOEFF_COUNT_BITWIDTH'(w_accept);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (batchEnd) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else begin
      r_sum <= w_next_sum;
      r_cnt <= w_next_cnt;
    end
  end

  // --------------------------------------------------------------------------
  // Result FIFO (show-ahead). Pointers carry one extra MSB so that equal
  // indices with differing MSBs mean full, identical pointers mean empty.
  // --------------------------------------------------------------------------
  logic [SUM_WIDTH-1:0]             r_mem_sum [c_DEPTH];
  logic [PCOEFF_COUNT_BITWIDTH-1:0] r_mem_cnt [c_DEPTH];
  logic [c_PW-1:0]                  r_wptr;
  logic [c_PW-1:0]                  r_rptr;
  logic                             r_slow;

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [c_PW-1:0] w_wptr_next;
  logic [c_PW-1:0] w_rptr_next;
  logic [c_PW-1:0] w_occ_next;
  logic [c_PW-1:0] w_free_next;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[c_PW-1] != r_rptr[c_PW-1]) &&
                   (r_wptr[c_PW-2:0] == r_rptr[c_PW-2:0]);
  assign w_pop   = !w_empty && resultReady;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can proceed.
  assign w_push  = batchEnd && (!w_full || w_pop);
  assign w_drop  = batchEnd && w_full && !w_pop;

  assign w_wptr_next = r_wptr + c_PW'(w_push);
  assign w_rptr_next = r_rptr + c_PW'(w_pop);
  assign w_occ_next  = w_wptr_next - w_rptr_next;
  assign w_free_next = c_PW'(c_DEPTH) - w_occ_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_slow <= 1'b0;
    end else begin
      r_wptr <= w_wptr_next;
      r_rptr <= w_rptr_next;
      r_slow <= (32'(w_free_next) <= 32'(SLOWDOWN_MARGIN));
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_sum[r_wptr[c_PW-2:0]] <= w_next_sum;
      r_mem_cnt[r_wptr[c_PW-2:0]] <= w_next_cnt;
    end
  end

  assign resultValid   = !w_empty;
  assign pcoeffSum     = w_empty ? '0 : r_mem_sum[r_rptr[c_PW-2:0]];
  assign pcoeffCount   = w_empty ? '0 : r_mem_cnt[r_rptr[c_PW-2:0]];
  assign slowDownInput = r_slow;

  // --------------------------------------------------------------------------
  // Sticky error flags: a new event in the clearing cycle keeps the flag set.
  // --------------------------------------------------------------------------
  logic r_range_err;
  logic r_cnt_ovf;
  logic r_dropped;

  logic w_range_evt;
  logic w_ovf_evt;

  assign w_range_evt = connectCountValid && !w_in_range;
  assign w_ovf_evt   = connectCountValid && w_cnt_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_range_err <= 1'b0;
      r_cnt_ovf   <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_range_err <= w_range_evt || (r_range_err && !errClear);
      r_cnt_ovf   <= w_ovf_evt   || (r_cnt_ovf   && !errClear);
      r_dropped   <= w_drop      || (r_dropped   && !errClear);
    end
  end

  assign rangeError    = r_range_err;
  assign countOverflow = r_cnt_ovf;
  assign resultDropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_pcoeff_batch_aggregator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcoeff_batch_aggregator
// Purpose  : Directed self-checking bench for pcoeff_batch_aggregator. A
//            second instance with a 3-bit batch counter covers overflow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcoeff_batch_aggregator;

  logic        clk;
  logic        rst;
  logic        connectCountValid;
  logic [5:0]  connectCount;
  logic        batchEnd;
  logic        resultReady;
  logic        errClear;

  logic        slowDownInput;
  logic        resultValid;
  logic [45:0] pcoeffSum;
  logic [9:0]  pcoeffCount;
  logic        rangeError;
  logic        countOverflow;
  logic        resultDropped;

  logic        s_slow;
  logic        s_valid;
  logic [38:0] s_sum;
  logic [2:0]  s_cnt;
  logic        s_range;
  logic        s_ovf;
  logic        s_drop;

  int n_checks;
  int n_fail;

  pcoeff_batch_aggregator dut (
    .clk               (clk),
    .rst               (rst),
    .connectCountValid (connectCountValid),
    .connectCount      (connectCount),
    .batchEnd          (batchEnd),
    .slowDownInput     (slowDownInput),
    .resultValid       (resultValid),
    .resultReady       (resultReady),
    .pcoeffSum         (pcoeffSum),
    .pcoeffCount       (pcoeffCount),
    .errClear          (errClear),
    .rangeError        (rangeError),
    .countOverflow     (countOverflow),
    .resultDropped     (resultDropped)
  );

  pcoeff_batch_aggregator #(.PCOEFF_COUNT_BITWIDTH(3)) dut_small (
    .clk               (clk),
    .rst               (rst),
    .connectCountValid (connectCountValid),
    .connectCount      (connectCount),
    .batchEnd          (batchEnd),
    .slowDownInput     (s_slow),
    .resultValid       (s_valid),
    .resultReady       (resultReady),
    .pcoeffSum         (s_sum),
    .pcoeffCount       (s_cnt),
    .errClear          (errClear),
    .rangeError        (s_range),
    .countOverflow     (s_ovf),
    .resultDropped     (s_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    connectCountValid = 1'b0;
    connectCount      = '0;
    batchEnd          = 1'b0;
    resultReady       = 1'b0;
    errClear          = 1'b0;
  endtask

  task automatic bot(input int cc, input logic be);
    connectCountValid = 1'b1;
    connectCount      = 6'(cc);
    batchEnd          = be;
    tick();
    connectCountValid = 1'b0;
    batchEnd          = 1'b0;
  endtask

  task automatic close_batch();
    batchEnd = 1'b1;
    tick();
    batchEnd = 1'b0;
  endtask

  task automatic sync_reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_valid", 64'(resultValid), 64'd0);
    check("rst_sum",   64'(pcoeffSum),   64'd0);
    check("rst_cnt",   64'(pcoeffCount), 64'd0);
    check("rst_slow",  64'(slowDownInput), 64'd0);
    check("rst_errs",  64'({rangeError, countOverflow, resultDropped}), 64'd0);
    rst = 1'b0;
    tick();

    // Bots 0, 3, 35 then closing bot 1
    bot(0, 1'b0);
    bot(3, 1'b0);
    bot(35, 1'b0);
    check("t1_pre_valid", 64'(resultValid), 64'd0);
    bot(1, 1'b1);
    check("t1_valid", 64'(resultValid), 64'd1);
    check("t1_sum",   64'(pcoeffSum),   64'd34359738379);
    check("t1_cnt",   64'(pcoeffCount), 64'd4);
    check("t1_slow",  64'(slowDownInput), 64'd0);
    tick();
    check("t1_hold_sum", 64'(pcoeffSum), 64'd34359738379);
    resultReady = 1'b1;
    tick();
    resultReady = 1'b0;
    check("t1_pop_valid", 64'(resultValid), 64'd0);
    check("t1_pop_sum",   64'(pcoeffSum),   64'd0);

    // Two consecutive batchEnds -> two empty batches
    batchEnd = 1'b1;
    tick();
    tick();
    batchEnd = 1'b0;
    check("t2_valid", 64'(resultValid), 64'd1);
    check("t2_sum0",  64'(pcoeffSum),   64'd0);
    check("t2_cnt0",  64'(pcoeffCount), 64'd0);
    check("t2_slow",  64'(slowDownInput), 64'd1);
    resultReady = 1'b1;
    tick();
    check("t2_valid1", 64'(resultValid), 64'd1);
    check("t2_cnt1",   64'(pcoeffCount), 64'd0);
    check("t2_slow1",  64'(slowDownInput), 64'd0);
    tick();
    resultReady = 1'b0;
    check("t2_empty", 64'(resultValid), 64'd0);

    // Range error in batch {2, 36}
    bot(2, 1'b0);
    bot(36, 1'b0);
    check("t3_range", 64'(rangeError), 64'd1);
    close_batch();
    check("t3_sum", 64'(pcoeffSum),   64'd4);
    check("t3_cnt", 64'(pcoeffCount), 64'd1);
    errClear = 1'b1;
    tick();
    errClear = 1'b0;
    check("t3_clear", 64'(rangeError), 64'd0);
    resultReady = 1'b1;
    tick();
    resultReady = 1'b0;

    // Five closes with no consumer: sums 1,2,4,8,16 with one bot each
    for (int i = 0; i < 5; i++) begin
      bot(i, 1'b1);
      if (i == 0) check("t4_slow_1st", 64'(slowDownInput), 64'd0);
      if (i == 1) check("t4_slow_2nd", 64'(slowDownInput), 64'd1);
      if (i == 3) check("t4_nodrop_4th", 64'(resultDropped), 64'd0);
    end
    check("t4_dropped", 64'(resultDropped), 64'd1);
    check("t4_head",    64'(pcoeffSum),     64'd1);
    errClear = 1'b1;
    tick();
    errClear = 1'b0;
    check("t4_clear", 64'(resultDropped), 64'd0);

    // Full FIFO: close (bot 5) and pop in the same cycle
    connectCountValid = 1'b1;
    connectCount      = 6'd5;
    batchEnd          = 1'b1;
    resultReady       = 1'b1;
    tick();
    connectCountValid = 1'b0;
    batchEnd          = 1'b0;
    resultReady       = 1'b0;
    check("t5_nodrop", 64'(resultDropped), 64'd0);
    check("t5_slow",   64'(slowDownInput), 64'd1);
    resultReady = 1'b1;
    check("t5_pop0", 64'(pcoeffSum), 64'd2);
    tick();
    check("t5_pop1", 64'(pcoeffSum), 64'd4);
    tick();
    check("t5_pop2", 64'(pcoeffSum), 64'd8);
    tick();
    check("t5_pop3", 64'(pcoeffSum), 64'd32);
    check("t5_pop3_cnt", 64'(pcoeffCount), 64'd1);
    tick();
    resultReady = 1'b0;
    check("t5_empty", 64'(resultValid), 64'd0);

    // Counter overflow on the 3-bit instance
    sync_reset_pulse();
    for (int i = 0; i < 8; i++) bot(0, (i == 7) ? 1'b1 : 1'b0);
    check("t6_s_valid", 64'(s_valid), 64'd1);
    check("t6_s_sum",   64'(s_sum),   64'd7);
    check("t6_s_cnt",   64'(s_cnt),   64'd7);
    check("t6_s_ovf",   64'(s_ovf),   64'd1);
    check("t6_sum",     64'(pcoeffSum),   64'd8);
    check("t6_cnt",     64'(pcoeffCount), 64'd8);
    check("t6_ovf",     64'(countOverflow), 64'd0);

    // Async reset mid-batch with results queued
    close_batch();
    close_batch();
    bot(4, 1'b0);
    check("t7_pre_valid", 64'(resultValid), 64'd1);
    rst = 1'b1;
    #1;
    check("t7_async_valid", 64'(resultValid),   64'd0);
    check("t7_async_sum",   64'(pcoeffSum),     64'd0);
    check("t7_async_cnt",   64'(pcoeffCount),   64'd0);
    check("t7_async_slow",  64'(slowDownInput), 64'd0);
    check("t7_async_s_ovf", 64'(s_ovf),         64'd0);
    tick();
    rst = 1'b0;
    tick();
    bot(2, 1'b1);
    check("t7_new_sum", 64'(pcoeffSum),   64'd4);
    check("t7_new_cnt", 64'(pcoeffCount), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
